// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the F/D/X/M/W hazard controller: bypass select codes,
// multdiv sequencer states and the bypass priority helper.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [1:0] BYP_RF = 2'd0;
    localparam logic [1:0] BYP_XM = 2'd1;
    localparam logic [1:0] BYP_MW = 2'd2;

    // The younger producer (X/M) always wins over the older one (M/W).
    function automatic logic [1:0] byp_select(input logic m_hit, input logic w_hit);
        logic [1:0] sel;
        sel = BYP_RF;
        if (m_hit) begin
            sel = BYP_XM;
        end else if (w_hit) begin
            sel = BYP_MW;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_seq.sv
// Multi-cycle mul/div sequencer: starts when a multdiv reaches X, holds the
// front of the pipe until the result is ready, then releases it for one capture.
module pipe_hazard_ctrl_md_seq
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY  = 32,
    parameter int MD_INTERNAL = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic x_md,
    input  logic md_done,
    output logic md_start,
    output logic md_busy,
    output logic freeze,
    output logic x_res_md
);

    localparam int CNT_BITS = $clog2(MD_LATENCY + 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(MD_LATENCY - 1);

    md_state_t           state;
    logic [CNT_BITS-1:0] cnt;
    logic                done;

    // External completion is only meaningful while BUSY; in IDLE it never reaches state.
    assign done = (MD_INTERNAL != 0) ? (cnt == CNT_LAST) : md_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (x_md) begin
                        state <= MD_BUSY;
                        cnt   <= '0;
                    end
                end
                MD_BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (done) begin
                        state <= MD_IDLE;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign md_start = (state == MD_IDLE) & x_md;
    assign md_busy  = (state == MD_BUSY);
    assign freeze   = md_start | (md_busy & ~done);
    assign x_res_md = md_busy & done;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/flush controller for the 5-stage pipeline: tracks X/M/W metadata,
// resolves load-use stalls, taken branches, multdiv freezes and X-stage bypassing.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_BITS    = 5,
    parameter int MD_LATENCY  = 32,
    parameter int MD_INTERNAL = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                d_valid,
    input  logic [REG_BITS-1:0] d_rs1,
    input  logic [REG_BITS-1:0] d_rs2,
    input  logic                d_use1,
    input  logic                d_use2,
    input  logic [REG_BITS-1:0] d_rd,
    input  logic                d_wen,
    input  logic                d_load,
    input  logic                d_md,
    input  logic                x_br_taken,
    input  logic                md_done,
    output logic                pc_en,
    output logic                fd_en,
    output logic                fd_flush,
    output logic                dx_flush,
    output logic [1:0]          byp_a,
    output logic [1:0]          byp_b,
    output logic                md_start,
    output logic                md_busy,
    output logic                x_res_md,
    output logic [REG_BITS-1:0] w_rd,
    output logic                w_wen
);

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic                wen;
        logic                load;
        logic                md;
        logic [REG_BITS-1:0] rs1;
        logic [REG_BITS-1:0] rs2;
        logic                use1;
        logic                use2;
    } x_meta_t;

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic                wen;
    } mw_meta_t;

    x_meta_t  d_meta;
    x_meta_t  x_q;
    mw_meta_t m_q;
    mw_meta_t w_q;
    logic     x_md;
    logic     freeze;
    logic     branch;
    logic     load_use;

    // A write to r0 is dropped here so no later check has to special-case it.
    always_comb begin
        d_meta = '0;
        if (d_valid) begin
            d_meta.valid = 1'b1;
            d_meta.rd    = d_rd;
            d_meta.wen   = d_wen & (d_rd != '0);
            d_meta.load  = d_load;
            d_meta.md    = d_md;
            d_meta.rs1   = d_rs1;
            d_meta.rs2   = d_rs2;
            d_meta.use1  = d_use1;
            d_meta.use2  = d_use2;
        end
    end

    assign x_md = x_q.valid & x_q.md;

    pipe_hazard_ctrl_md_seq #(
        .MD_LATENCY (MD_LATENCY),
        .MD_INTERNAL(MD_INTERNAL)
    ) u_md_seq (
        .clock   (clock),
        .reset   (reset),
        .x_md    (x_md),
        .md_done (md_done),
        .md_start(md_start),
        .md_busy (md_busy),
        .freeze  (freeze),
        .x_res_md(x_res_md)
    );

    // A taken branch squashes whatever sits in D, so a load-use there is moot.
    assign branch   = ~freeze & x_br_taken;
    assign load_use = ~freeze & ~x_br_taken & x_q.valid & x_q.load & x_q.wen & d_valid &
                      ((d_use1 & (d_rs1 == x_q.rd)) | (d_use2 & (d_rs2 == x_q.rd)));

    assign pc_en    = ~freeze & ~load_use;
    assign fd_en    = ~freeze & ~load_use;
    assign fd_flush = branch;
    assign dx_flush = branch | load_use;

    function automatic logic fwd_hit(input mw_meta_t stage, input logic [REG_BITS-1:0] rs,
                                     input logic use_rs);
        return use_rs & (rs != '0) & stage.valid & stage.wen & (stage.rd == rs);
    endfunction

    assign byp_a = byp_select(x_q.valid & fwd_hit(m_q, x_q.rs1, x_q.use1),
                              x_q.valid & fwd_hit(w_q, x_q.rs1, x_q.use1));
    assign byp_b = byp_select(x_q.valid & fwd_hit(m_q, x_q.rs2, x_q.use2),
                              x_q.valid & fwd_hit(w_q, x_q.rs2, x_q.use2));

    // During a freeze the multdiv stays in X and M drains as a bubble; W always advances.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            w_q <= m_q;
            if (freeze) begin
                m_q <= '0;
            end else begin
                m_q <= '{valid: x_q.valid, rd: x_q.rd, wen: x_q.wen};
                x_q <= dx_flush ? '0 : d_meta;
            end
        end
    end

    assign w_wen = w_q.valid & w_q.wen & (w_q.rd != '0);
    assign w_rd  = w_q.rd;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: one internally-timed and one externally-timed
// instance driven by directed and random instruction streams against a stage model.
module tb_pipe_hazard_ctrl;

    localparam int RB  = 5;
    localparam int LAT = 4;

    logic          clock;
    logic          reset;
    logic          d_valid;
    logic [RB-1:0] d_rs1;
    logic [RB-1:0] d_rs2;
    logic          d_use1;
    logic          d_use2;
    logic [RB-1:0] d_rd;
    logic          d_wen;
    logic          d_load;
    logic          d_md;
    logic          x_br_taken;
    logic          md_done;

    logic          pc_en    [2];
    logic          fd_en    [2];
    logic          fd_flush [2];
    logic          dx_flush [2];
    logic [1:0]    byp_a    [2];
    logic [1:0]    byp_b    [2];
    logic          md_start [2];
    logic          md_busy  [2];
    logic          x_res_md [2];
    logic [RB-1:0] w_rd     [2];
    logic          w_wen    [2];

    pipe_hazard_ctrl #(.REG_BITS(RB), .MD_LATENCY(LAT), .MD_INTERNAL(1)) dut_int (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use1(d_use1), .d_use2(d_use2), .d_rd(d_rd), .d_wen(d_wen), .d_load(d_load),
        .d_md(d_md), .x_br_taken(x_br_taken), .md_done(md_done),
        .pc_en(pc_en[0]), .fd_en(fd_en[0]), .fd_flush(fd_flush[0]), .dx_flush(dx_flush[0]),
        .byp_a(byp_a[0]), .byp_b(byp_b[0]), .md_start(md_start[0]), .md_busy(md_busy[0]),
        .x_res_md(x_res_md[0]), .w_rd(w_rd[0]), .w_wen(w_wen[0])
    );

    pipe_hazard_ctrl #(.REG_BITS(RB), .MD_LATENCY(LAT), .MD_INTERNAL(0)) dut_ext (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use1(d_use1), .d_use2(d_use2), .d_rd(d_rd), .d_wen(d_wen), .d_load(d_load),
        .d_md(d_md), .x_br_taken(x_br_taken), .md_done(md_done),
        .pc_en(pc_en[1]), .fd_en(fd_en[1]), .fd_flush(fd_flush[1]), .dx_flush(dx_flush[1]),
        .byp_a(byp_a[1]), .byp_b(byp_b[1]), .md_start(md_start[1]), .md_busy(md_busy[1]),
        .x_res_md(x_res_md[1]), .w_rd(w_rd[1]), .w_wen(w_wen[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          valid;
        bit [RB-1:0] rd;
        bit          wen;
        bit          load;
        bit          md;
        bit [RB-1:0] rs1;
        bit [RB-1:0] rs2;
        bit          use1;
        bit          use2;
    } instr_t;

    // Instruction occupying each stage, plus how long the multdiv has been running.
    instr_t st_x [2];
    instr_t st_m [2];
    instr_t st_w [2];
    bit     busy [2];
    int     busy_cycles [2];

    int tests = 0;
    int fails = 0;

    function automatic instr_t bubble();
        instr_t b;
        b = '{default: 0};
        return b;
    endfunction

    function automatic instr_t from_d();
        instr_t i;
        i = bubble();
        if (d_valid) begin
            i.valid = 1'b1;
            i.rd    = d_rd;
            i.wen   = d_wen && (d_rd != 0);
            i.load  = d_load;
            i.md    = d_md;
            i.rs1   = d_rs1;
            i.rs2   = d_rs2;
            i.use1  = d_use1;
            i.use2  = d_use2;
        end
        return i;
    endfunction

    function automatic bit ref_done(int k);
        if (k == 0) return (busy_cycles[k] + 1) == LAT;
        return md_done;
    endfunction

    function automatic bit ref_freeze(int k);
        if (busy[k]) return !ref_done(k);
        return st_x[k].valid && st_x[k].md;
    endfunction

    function automatic bit ref_load_use(int k);
        instr_t x;
        x = st_x[k];
        if (ref_freeze(k) || x_br_taken) return 0;
        if (!(x.valid && x.load && x.wen && d_valid)) return 0;
        return (d_use1 && d_rs1 == x.rd) || (d_use2 && d_rs2 == x.rd);
    endfunction

    function automatic logic [1:0] ref_byp(int k, bit use_rs, bit [RB-1:0] rs);
        if (!st_x[k].valid || !use_rs || rs == 0) return 2'd0;
        if (st_m[k].valid && st_m[k].wen && st_m[k].rd == rs) return 2'd1;
        if (st_w[k].valid && st_w[k].wen && st_w[k].rd == rs) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            st_x[k] = bubble();
            st_m[k] = bubble();
            st_w[k] = bubble();
            busy[k] = 0;
            busy_cycles[k] = 0;
        end
    endtask

    task automatic check_output(input string tag, input int k, input logic [7:0] obs,
                                input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic set_d(input bit v, input bit [RB-1:0] rd, input bit [RB-1:0] rs1,
                         input bit [RB-1:0] rs2, input bit u1, input bit u2, input bit wen,
                         input bit ld, input bit md);
        d_valid = v;  d_rd = rd;    d_rs1 = rs1;   d_rs2 = rs2;
        d_use1  = u1; d_use2 = u2;  d_wen = wen;   d_load = ld;  d_md = md;
    endtask

    task automatic set_nop();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Waits 1 unit past the falling edge and compares every output with the model.
    task automatic apply_stimulus();
        bit frz, lu, br;
        #1;
        for (int k = 0; k < 2; k++) begin
            frz = ref_freeze(k);
            lu  = ref_load_use(k);
            br  = !frz && x_br_taken;
            check_output("pc_en",    k, 8'(pc_en[k]),    8'(!frz && !lu));
            check_output("fd_en",    k, 8'(fd_en[k]),    8'(!frz && !lu));
            check_output("fd_flush", k, 8'(fd_flush[k]), 8'(br));
            check_output("dx_flush", k, 8'(dx_flush[k]), 8'(br || lu));
            check_output("byp_a",    k, 8'(byp_a[k]),    8'(ref_byp(k, st_x[k].use1, st_x[k].rs1)));
            check_output("byp_b",    k, 8'(byp_b[k]),    8'(ref_byp(k, st_x[k].use2, st_x[k].rs2)));
            check_output("md_start", k, 8'(md_start[k]), 8'(!busy[k] && frz));
            check_output("md_busy",  k, 8'(md_busy[k]),  8'(busy[k]));
            check_output("x_res_md", k, 8'(x_res_md[k]), 8'(busy[k] && ref_done(k)));
            check_output("w_wen",    k, 8'(w_wen[k]),    8'(st_w[k].valid && st_w[k].wen));
            if (st_w[k].valid) check_output("w_rd", k, 8'(w_rd[k]), 8'(st_w[k].rd));
        end
    endtask

    // Advances the model by one clock and waits for the next falling edge.
    task automatic step_cycle();
        bit frz, lu, br, done;
        for (int k = 0; k < 2; k++) begin
            frz  = ref_freeze(k);
            lu   = ref_load_use(k);
            br   = !frz && x_br_taken;
            done = ref_done(k);
            st_w[k] = st_m[k];
            if (frz) begin
                st_m[k] = bubble();
            end else begin
                st_m[k] = st_x[k];
                st_x[k] = (br || lu) ? bubble() : from_d();
            end
            if (busy[k]) begin
                if (done) busy[k] = 0;
                else busy_cycles[k]++;
            end else if (frz) begin
                busy[k] = 1;
                busy_cycles[k] = 0;
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        set_nop();
        x_br_taken = 0;
        reset = 1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            check_output("rst_pc_en",    k, 8'(pc_en[k]),    8'd1);
            check_output("rst_fd_en",    k, 8'(fd_en[k]),    8'd1);
            check_output("rst_fd_flush", k, 8'(fd_flush[k]), 8'd0);
            check_output("rst_dx_flush", k, 8'(dx_flush[k]), 8'd0);
            check_output("rst_byp_a",    k, 8'(byp_a[k]),    8'd0);
            check_output("rst_byp_b",    k, 8'(byp_b[k]),    8'd0);
            check_output("rst_md_start", k, 8'(md_start[k]), 8'd0);
            check_output("rst_md_busy",  k, 8'(md_busy[k]),  8'd0);
            check_output("rst_x_res_md", k, 8'(x_res_md[k]), 8'd0);
            check_output("rst_w_wen",    k, 8'(w_wen[k]),    8'd0);
            check_output("rst_w_rd",     k, 8'(w_rd[k]),     8'd0);
        end
        @(negedge clock);
        reset = 0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        reset = 1;
        x_br_taken = 0;
        md_done = 0;
        set_nop();
        model_reset();
        @(negedge clock);
        do_reset();

        // Back-to-back dependency: producer in M when consumer reaches X.
        set_d(1, 3, 1, 2, 1, 1, 1, 0, 0); apply_stimulus(); step_cycle();
        set_d(1, 4, 3, 3, 1, 1, 1, 0, 0); apply_stimulus(); step_cycle();
        set_nop(); apply_stimulus();
        for (int k = 0; k < 2; k++) begin
            check_output("dep_byp_a", k, 8'(byp_a[k]), 8'd1);
            check_output("dep_byp_b", k, 8'(byp_b[k]), 8'd1);
        end
        step_cycle();
        apply_stimulus(); step_cycle();

        // One instruction gap: producer in W.
        set_d(1, 3, 1, 2, 1, 1, 1, 0, 0); apply_stimulus(); step_cycle();
        set_nop();                         apply_stimulus(); step_cycle();
        set_d(1, 4, 3, 3, 1, 1, 1, 0, 0); apply_stimulus(); step_cycle();
        set_nop(); apply_stimulus();
        for (int k = 0; k < 2; k++) begin
            check_output("gap_byp_a", k, 8'(byp_a[k]), 8'd2);
            check_output("gap_byp_b", k, 8'(byp_b[k]), 8'd2);
        end
        step_cycle();

        // Load-use: one stall cycle, then the load result comes from M/W.
        set_d(1, 5, 1, 0, 1, 0, 1, 1, 0); apply_stimulus(); step_cycle();
        set_d(1, 6, 5, 1, 1, 1, 1, 0, 0); apply_stimulus();
        for (int k = 0; k < 2; k++) begin
            check_output("lu_pc_en",    k, 8'(pc_en[k]),    8'd0);
            check_output("lu_fd_en",    k, 8'(fd_en[k]),    8'd0);
            check_output("lu_dx_flush", k, 8'(dx_flush[k]), 8'd1);
        end
        step_cycle();
        apply_stimulus();
        for (int k = 0; k < 2; k++) check_output("lu_release", k, 8'(pc_en[k]), 8'd1);
        step_cycle();
        set_nop(); apply_stimulus();
        for (int k = 0; k < 2; k++) begin
            check_output("lu_byp_a", k, 8'(byp_a[k]), 8'd2);
            check_output("lu_byp_b", k, 8'(byp_b[k]), 8'd0);
        end
        step_cycle();

        // Branch taken while a load-use is pending.
        set_d(1, 5, 1, 0, 1, 0, 1, 1, 0); apply_stimulus(); step_cycle();
        set_d(1, 6, 5, 1, 1, 1, 1, 0, 0);
        x_br_taken = 1;
        apply_stimulus();
        for (int k = 0; k < 2; k++) begin
            check_output("br_fd_flush", k, 8'(fd_flush[k]), 8'd1);
            check_output("br_dx_flush", k, 8'(dx_flush[k]), 8'd1);
            check_output("br_pc_en",    k, 8'(pc_en[k]),    8'd1);
        end
        step_cycle();
        x_br_taken = 0;

        // Writes to r0 are never bypassed nor committed.
        set_d(1, 0, 1, 2, 1, 1, 1, 0, 0); apply_stimulus(); step_cycle();
        set_d(1, 7, 0, 0, 1, 1, 1, 0, 0); apply_stimulus(); step_cycle();
        set_nop(); apply_stimulus();
        for (int k = 0; k < 2; k++) check_output("r0_byp_a", k, 8'(byp_a[k]), 8'd0);
        step_cycle();
        apply_stimulus();
        for (int k = 0; k < 2; k++) check_output("r0_w_wen", k, 8'(w_wen[k]), 8'd0);
        step_cycle();
        apply_stimulus();
        for (int k = 0; k < 2; k++) begin
            check_output("r7_w_wen", k, 8'(w_wen[k]), 8'd1);
            check_output("r7_w_rd",  k, 8'(w_rd[k]),  8'd7);
        end
        step_cycle();

        // Multdiv: internal timer finishes after LAT busy cycles, external waits on md_done.
        set_d(1, 8, 1, 2, 1, 1, 1, 0, 1); apply_stimulus(); step_cycle();
        set_nop();
        for (int i = 0; i < 12; i++) begin
            md_done = (i == 10);
            apply_stimulus();
            if (i == 0) begin
                check_output("md_start_int", 0, 8'(md_start[0]), 8'd1);
                check_output("md_start_ext", 1, 8'(md_start[1]), 8'd1);
            end
            if (i < 4)   check_output("md_freeze_int", 0, 8'(pc_en[0]), 8'd0);
            if (i == 4) begin
                check_output("md_res_int",   0, 8'(x_res_md[0]), 8'd1);
                check_output("md_adv_int",   0, 8'(pc_en[0]),    8'd1);
            end
            if (i < 10)  check_output("md_freeze_ext", 1, 8'(pc_en[1]), 8'd0);
            if (i == 10) check_output("md_res_ext",    1, 8'(x_res_md[1]), 8'd1);
            step_cycle();
        end

        // md_done while idle must not start anything.
        md_done = 1;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus();
            check_output("idle_md_busy", 1, 8'(md_busy[1]), 8'd0);
            step_cycle();
        end
        md_done = 0;

        // Reset in the middle of a multdiv aborts it.
        set_d(1, 9, 1, 2, 1, 1, 1, 0, 1); apply_stimulus(); step_cycle();
        set_nop(); apply_stimulus(); step_cycle();
        apply_stimulus();
        for (int k = 0; k < 2; k++) check_output("busy_before_rst", k, 8'(md_busy[k]), 8'd1);
        do_reset();

        // Random instruction mix over a small register set to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset();
            d_valid    = ($urandom_range(0, 3) != 0);
            d_rd       = RB'($urandom_range(0, 3));
            d_rs1      = RB'($urandom_range(0, 3));
            d_rs2      = RB'($urandom_range(0, 3));
            d_use1     = ($urandom_range(0, 1) != 0);
            d_use2     = ($urandom_range(0, 1) != 0);
            d_wen      = ($urandom_range(0, 3) != 0);
            d_load     = ($urandom_range(0, 3) == 0);
            d_md       = ($urandom_range(0, 19) == 0);
            x_br_taken = ($urandom_range(0, 7) == 0);
            md_done    = ($urandom_range(0, 3) == 0);
            apply_stimulus();
            step_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
